// File: rtl/simd_sequencer_if.sv
// Bus bundle between the SIMD sequencer and its environment (instruction memory,
// datapath controls, host start/step/stall handshake).
interface simd_sequencer_if #(
   parameter int INS_ADDR_WIDTH = 10,
   parameter int ADDR_WIDTH     = 10,
   parameter int OPCODE_WIDTH   = 4,
   parameter int OP_SEL_WIDTH   = 2
);
   logic                                  start;
   logic                                  step;
   logic                                  stall;
   logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0]  ins_data;
   logic [INS_ADDR_WIDTH-1:0]             pc;
   logic [ADDR_WIDTH-1:0]                 a_addr;
   logic [ADDR_WIDTH-1:0]                 b_addr;
   logic [ADDR_WIDTH-1:0]                 r_addr;
   logic [OP_SEL_WIDTH-1:0]               pe_op;
   logic [1:0]                            dot_ctrl;
   logic                                  write_en;
   logic                                  r_select;
   logic                                  issue_valid;
   logic                                  busy;
   logic                                  done;
   logic                                  err;

   modport master (
      input  start, step, stall, ins_data,
      output pc, a_addr, b_addr, r_addr, pe_op, dot_ctrl, write_en,
             r_select, issue_valid, busy, done, err
   );

   modport slave (
      output start, step, stall, ins_data,
      input  pc, a_addr, b_addr, r_addr, pe_op, dot_ctrl, write_en,
             r_select, issue_valid, busy, done, err
   );
endinterface

// File: rtl/simd_sequencer.sv
// Instruction fetch/decode/issue sequencer: start/done FSM, HALT, one-level
// hardware loop and a sticky illegal-instruction flag.
module simd_sequencer #(
   parameter int INS_ADDR_WIDTH = 10,
   parameter int ADDR_WIDTH     = 10,
   parameter int OPCODE_WIDTH   = 4,
   parameter int OP_SEL_WIDTH   = 2
) (
   input logic              clk,
   input logic              rstn,
   simd_sequencer_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

   localparam logic [OPCODE_WIDTH-1:0] OP_NOP    = OPCODE_WIDTH'(0);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD    = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB    = OPCODE_WIDTH'(2);
   localparam logic [OPCODE_WIDTH-1:0] OP_MUL    = OPCODE_WIDTH'(3);
   localparam logic [OPCODE_WIDTH-1:0] OP_DSHIFT = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_DACC   = OPCODE_WIDTH'(5);
   localparam logic [OPCODE_WIDTH-1:0] OP_DCLR   = OPCODE_WIDTH'(6);
   localparam logic [OPCODE_WIDTH-1:0] OP_PASSB  = OPCODE_WIDTH'(7);
   localparam logic [OPCODE_WIDTH-1:0] OP_LOOP   = OPCODE_WIDTH'(8);
   localparam logic [OPCODE_WIDTH-1:0] OP_HALT   = OPCODE_WIDTH'(9);

   localparam logic [OP_SEL_WIDTH-1:0] PE_PASSB = OP_SEL_WIDTH'(0);
   localparam logic [OP_SEL_WIDTH-1:0] PE_ADD   = OP_SEL_WIDTH'(1);
   localparam logic [OP_SEL_WIDTH-1:0] PE_SUB   = OP_SEL_WIDTH'(2);
   localparam logic [OP_SEL_WIDTH-1:0] PE_MUL   = OP_SEL_WIDTH'(3);

   state_t                      state_q, state_d;
   logic [INS_ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]       a_q, a_d, b_q, b_d, r_q, r_d;
   logic [OP_SEL_WIDTH-1:0]     pe_op_q, pe_op_d;
   logic [1:0]                  dot_q, dot_d;
   logic                        we_q, we_d, rsel_q, rsel_d;
   logic                        iv_q, iv_d, err_q, err_d;
   logic                        loop_act_q, loop_act_d;
   logic [INS_ADDR_WIDTH-1:0]   loop_start_q, loop_start_d;
   logic [INS_ADDR_WIDTH-1:0]   loop_end_q, loop_end_d;
   logic [ADDR_WIDTH-1:0]       loop_rem_q, loop_rem_d;

   logic [OPCODE_WIDTH-1:0]     ins_op;
   logic [ADDR_WIDTH-1:0]       ins_a, ins_b, ins_r;
   logic [INS_ADDR_WIDTH-1:0]   loop_end_field;
   logic [INS_ADDR_WIDTH:0]     pc_inc;

   assign ins_op = bus.ins_data[OPCODE_WIDTH-1:0];
   assign ins_r  = bus.ins_data[OPCODE_WIDTH +: ADDR_WIDTH];
   assign ins_b  = bus.ins_data[OPCODE_WIDTH+ADDR_WIDTH +: ADDR_WIDTH];
   assign ins_a  = bus.ins_data[OPCODE_WIDTH+2*ADDR_WIDTH +: ADDR_WIDTH];
   // One extra bit so a LOOP at the last address sees pc+1 beyond any end field.
   assign pc_inc = {1'b0, pc_q} + 1'b1;

   generate
      if (ADDR_WIDTH >= INS_ADDR_WIDTH) begin : g_end_trunc
         assign loop_end_field = ins_r[INS_ADDR_WIDTH-1:0];
      end else begin : g_end_ext
         assign loop_end_field = {{(INS_ADDR_WIDTH-ADDR_WIDTH){1'b0}}, ins_r};
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      a_d          = a_q;
      b_d          = b_q;
      r_d          = r_q;
      pe_op_d      = pe_op_q;
      rsel_d       = rsel_q;
      we_d         = 1'b0;
      dot_d        = 2'b00;
      iv_d         = 1'b0;
      err_d        = err_q;
      loop_act_d   = loop_act_q;
      loop_start_d = loop_start_q;
      loop_end_d   = loop_end_q;
      loop_rem_d   = loop_rem_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d    = S_FETCH;
               pc_d       = '0;
               err_d      = 1'b0;
               loop_act_d = 1'b0;
               loop_rem_d = '0;
            end
         end
         S_FETCH: state_d = S_ISSUE;
         S_ISSUE: begin
            if (bus.step && !bus.stall) begin
               iv_d    = 1'b1;
               a_d     = ins_a;
               b_d     = ins_b;
               r_d     = ins_r;
               pe_op_d = PE_PASSB;
               rsel_d  = 1'b0;
               case (ins_op)
                  OP_NOP:    ;
                  OP_ADD:    begin pe_op_d = PE_ADD; we_d = 1'b1; end
                  OP_SUB:    begin pe_op_d = PE_SUB; we_d = 1'b1; end
                  OP_MUL:    begin pe_op_d = PE_MUL; we_d = 1'b1; end
                  OP_DSHIFT: begin pe_op_d = PE_MUL; we_d = 1'b1; rsel_d = 1'b1; dot_d = 2'b01; end
                  OP_DACC:   begin pe_op_d = PE_MUL; we_d = 1'b1; rsel_d = 1'b1; dot_d = 2'b10; end
                  OP_DCLR:   begin pe_op_d = PE_MUL; we_d = 1'b1; rsel_d = 1'b1; dot_d = 2'b11; end
                  OP_PASSB:  begin pe_op_d = PE_PASSB; we_d = 1'b1; end
                  OP_LOOP: begin
                     if (loop_act_q) begin
                        err_d = 1'b1;
                     end else if ({1'b0, loop_end_field} >= pc_inc) begin
                        // An end address behind the body leaves the loop unarmed.
                        loop_act_d   = 1'b1;
                        loop_start_d = pc_inc[INS_ADDR_WIDTH-1:0];
                        loop_end_d   = loop_end_field;
                        loop_rem_d   = (ins_a == '0) ? '0 : ins_a - 1'b1;
                     end
                  end
                  OP_HALT:   ;
                  default:   err_d = 1'b1;
               endcase

               if (ins_op == OP_HALT) begin
                  state_d = S_DONE;
               end else if (loop_act_q && pc_q == loop_end_q && loop_rem_q != '0) begin
                  state_d    = S_FETCH;
                  pc_d       = loop_start_q;
                  loop_rem_d = loop_rem_q - 1'b1;
               end else begin
                  if (loop_act_q && pc_q == loop_end_q) loop_act_d = 1'b0;
                  if (pc_q == '1) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_FETCH;
                     pc_d    = pc_inc[INS_ADDR_WIDTH-1:0];
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         r_q          <= '0;
         pe_op_q      <= '0;
         dot_q        <= 2'b00;
         we_q         <= 1'b0;
         rsel_q       <= 1'b0;
         iv_q         <= 1'b0;
         err_q        <= 1'b0;
         loop_act_q   <= 1'b0;
         loop_start_q <= '0;
         loop_end_q   <= '0;
         loop_rem_q   <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         a_q          <= a_d;
         b_q          <= b_d;
         r_q          <= r_d;
         pe_op_q      <= pe_op_d;
         dot_q        <= dot_d;
         we_q         <= we_d;
         rsel_q       <= rsel_d;
         iv_q         <= iv_d;
         err_q        <= err_d;
         loop_act_q   <= loop_act_d;
         loop_start_q <= loop_start_d;
         loop_end_q   <= loop_end_d;
         loop_rem_q   <= loop_rem_d;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.a_addr      = a_q;
   assign bus.b_addr      = b_q;
   assign bus.r_addr      = r_q;
   assign bus.pe_op       = pe_op_q;
   assign bus.dot_ctrl    = dot_q;
   assign bus.write_en    = we_q;
   assign bus.r_select    = rsel_q;
   assign bus.issue_valid = iv_q;
   assign bus.err         = err_q;
   assign bus.busy        = (state_q == S_FETCH) || (state_q == S_ISSUE);
   assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_simd_sequencer.sv
// Scoreboard bench for simd_sequencer: directed programs, expected issue
// records queued by the stimulus and checked by a separate monitor.
module tb_simd_sequencer;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   simd_sequencer_if #(.INS_ADDR_WIDTH(10), .ADDR_WIDTH(10), .OPCODE_WIDTH(4), .OP_SEL_WIDTH(2)) bus ();

   simd_sequencer #(.INS_ADDR_WIDTH(10), .ADDR_WIDTH(10), .OPCODE_WIDTH(4), .OP_SEL_WIDTH(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct packed {
      logic [1:0] pe;
      logic [1:0] dot;
      logic       we;
      logic       rs;
      logic [9:0] a;
      logic [9:0] b;
      logic [9:0] r;
   } exp_t;

   logic [33:0] imem [0:1023];
   exp_t        exp_q [$];
   int          tests = 0;
   int          fails = 0;
   int          issues = 0;
   int          writes = 0;
   int          idle_bad = 0;

   always @(posedge clk) bus.ins_data <= imem[bus.pc];

   // Monitor: every issue pulse is matched against the oldest queued expectation.
   always @(negedge clk) begin
      if (rstn) begin
         if (bus.issue_valid) begin
            exp_t got;
            got = '{pe: bus.pe_op, dot: bus.dot_ctrl, we: bus.write_en, rs: bus.r_select,
                    a: bus.a_addr, b: bus.b_addr, r: bus.r_addr};
            issues++;
            if (bus.write_en) writes++;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL issue_unexpected: got %h at pc %0d, required no issue", got, bus.pc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (got !== e) begin
                  fails++;
                  $display("FAIL issue_fields: got %h required %h", got, e);
               end
               $display("[TB] issue pe=%0d dot=%0d we=%0b rs=%0b a=%0d b=%0d r=%0d", got.pe, got.dot,
                        got.we, got.rs, got.a, got.b, got.r);
            end
         end else if (bus.write_en || bus.dot_ctrl != 2'b00) begin
            idle_bad++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   function automatic logic [33:0] ins(input int op, input int a, input int b, input int r);
      logic [9:0] fa, fb, fr;
      logic [3:0] fo;
      fa = 10'(a); fb = 10'(b); fr = 10'(r); fo = 4'(op);
      return {fa, fb, fr, fo};
   endfunction

   task automatic push(input int pe, input int dot, input int we, input int rs,
                       input int a, input int b, input int r);
      exp_t e;
      e = '{pe: 2'(pe), dot: 2'(dot), we: 1'(we), rs: 1'(rs), a: 10'(a), b: 10'(b), r: 10'(r)};
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) imem[i] = '0;
   endtask

   task automatic run_prog(input int budget);
      int n;
      n = 0;
      issues = 0;
      writes = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      while (!bus.done && n < budget) begin
         tick();
         n++;
      end
      check("done_reached", 32'(bus.done), 1);
      tick();
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0;
      bus.step  = 1'b1;
      bus.stall = 1'b0;
      clear_mem();
      rstn = 1'b0;
      repeat (3) tick();
      rstn = 1'b1;
      tick();

      // Reset state
      check("rst_pc", 32'(bus.pc), 0);
      check("rst_busy_done_err", {bus.busy, bus.done, bus.err}, 0);
      check("rst_ctrl", {bus.issue_valid, bus.write_en, bus.r_select, bus.pe_op, bus.dot_ctrl}, 0);
      check("rst_addr", {bus.a_addr, bus.b_addr, bus.r_addr}, 0);

      // ADD then HALT
      imem[0] = ins(1, 3, 4, 5);
      imem[1] = ins(9, 0, 0, 0);
      push(1, 0, 1, 0, 3, 4, 5);
      push(0, 0, 0, 0, 0, 0, 0);
      run_prog(50);
      check("add_writes", writes, 1);
      check("add_halt_pc", 32'(bus.pc), 1);
      check("add_err", 32'(bus.err), 0);

      // Dot-product controls
      clear_mem();
      imem[0] = ins(4, 7, 8, 9);
      imem[1] = ins(5, 10, 11, 12);
      imem[2] = ins(6, 13, 14, 15);
      imem[3] = ins(9, 0, 0, 0);
      push(3, 1, 1, 1, 7, 8, 9);
      push(3, 2, 1, 1, 10, 11, 12);
      push(3, 3, 1, 1, 13, 14, 15);
      push(0, 0, 0, 0, 0, 0, 0);
      run_prog(50);
      check("dot_writes", writes, 3);

      // Hardware loop: body pc1..pc2 three times
      clear_mem();
      imem[0] = ins(8, 3, 0, 2);
      imem[1] = ins(3, 1, 2, 3);
      imem[2] = ins(2, 4, 5, 6);
      imem[3] = ins(9, 0, 0, 0);
      push(0, 0, 0, 0, 3, 0, 2);
      for (int k = 0; k < 3; k++) begin
         push(3, 0, 1, 0, 1, 2, 3);
         push(2, 0, 1, 0, 4, 5, 6);
      end
      push(0, 0, 0, 0, 0, 0, 0);
      run_prog(100);
      check("loop_writes", writes, 6);
      check("loop_issues", issues, 8);
      check("loop_err", 32'(bus.err), 0);
      check("loop_halt_pc", 32'(bus.pc), 3);

      // Stall held for 5 cycles in ISSUE
      clear_mem();
      imem[0] = ins(1, 20, 21, 22);
      imem[1] = ins(9, 0, 0, 0);
      push(1, 0, 1, 0, 20, 21, 22);
      push(0, 0, 0, 0, 0, 0, 0);
      issues = 0;
      bus.stall = 1'b1;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         check("stall_no_issue", {bus.issue_valid, bus.write_en}, 0);
         check("stall_pc", 32'(bus.pc), 0);
      end
      bus.stall = 1'b0;
      tick();
      check("stall_release_issue", 32'(bus.issue_valid), 1);
      check("stall_release_pc", 32'(bus.pc), 1);
      begin
         int n;
         n = 0;
         while (!bus.done && n < 50) begin tick(); n++; end
         check("stall_done", 32'(bus.done), 1);
         tick();
         check("stall_issues", issues, 2);
         exp_q.delete();
      end

      // Illegal opcode sets err
      clear_mem();
      imem[0] = ins(12, 1, 2, 3);
      imem[1] = ins(9, 0, 0, 0);
      push(0, 0, 0, 0, 1, 2, 3);
      push(0, 0, 0, 0, 0, 0, 0);
      run_prog(50);
      check("illegal_err", 32'(bus.err), 1);
      check("illegal_writes", writes, 0);

      // Nested LOOP: start from DONE clears err, nested loop sets it again
      clear_mem();
      imem[0] = ins(8, 2, 0, 2);
      imem[1] = ins(8, 5, 0, 9);
      imem[2] = ins(0, 0, 0, 0);
      imem[3] = ins(9, 0, 0, 0);
      push(0, 0, 0, 0, 2, 0, 2);
      push(0, 0, 0, 0, 5, 0, 9);
      push(0, 0, 0, 0, 0, 0, 0);
      push(0, 0, 0, 0, 5, 0, 9);
      push(0, 0, 0, 0, 0, 0, 0);
      push(0, 0, 0, 0, 0, 0, 0);
      issues = 0;
      writes = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("start_clears_err", 32'(bus.err), 0);
      begin
         int n;
         n = 0;
         while (!bus.done && n < 100) begin tick(); n++; end
         check("nested_done", 32'(bus.done), 1);
         tick();
      end
      check("nested_err", 32'(bus.err), 1);
      check("nested_issues", issues, 6);
      check("nested_writes", writes, 0);
      check("nested_queue", exp_q.size(), 0);
      exp_q.delete();

      // Reset in the middle of the loop program at pc=1
      clear_mem();
      imem[0] = ins(8, 3, 0, 2);
      imem[1] = ins(3, 1, 2, 3);
      imem[2] = ins(2, 4, 5, 6);
      imem[3] = ins(9, 0, 0, 0);
      push(0, 0, 0, 0, 3, 0, 2);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      begin
         int n;
         n = 0;
         while (bus.pc != 10'd1 && n < 20) begin tick(); n++; end
         check("midloop_pc1", 32'(bus.pc), 1);
      end
      rstn = 1'b0;
      tick();
      check("midrst_pc", 32'(bus.pc), 0);
      check("midrst_status", {bus.busy, bus.done, bus.err, bus.issue_valid}, 0);
      check("midrst_ctrl", {bus.write_en, bus.r_select, bus.pe_op, bus.dot_ctrl}, 0);
      check("midrst_addr", {bus.a_addr, bus.b_addr, bus.r_addr}, 0);
      exp_q.delete();
      rstn = 1'b1;
      tick();

      // All-NOP program runs to the last address without wrapping
      clear_mem();
      for (int k = 0; k < 1024; k++) push(0, 0, 0, 0, 0, 0, 0);
      run_prog(3000);
      check("nop_issues", issues, 1024);
      check("nop_last_pc", 32'(bus.pc), 1023);
      repeat (5) tick();
      check("nop_no_wrap", issues, 1024);
      check("nop_still_done", 32'(bus.done), 1);

      check("idle_ctrl_zero", idle_bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
